data_memory_ws: RTL and testbench
=================================

Name: data_memory_ws

Overview:
- Parametrised, byte-addressed data memory for the MIPS datapath. Successor to the single-cycle word memory.
- Adds depth and wait-state parameters, a request/ready handshake, byte and halfword stores, and signed or unsigned sub-word loads.
- Adds misalignment detection and a registered read port.
- Sits between the MEM stage and the pipeline stall logic; `busy` feeds the hazard unit.

Parameters:
- DEPTH, 128, number of 32-bit words; must be a power of two, at least 4.
- WAIT, 2, extra wait states per access; range 0..15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  1  access request, sampled only in IDLE
- we  input  1  1 = store, 0 = load
- size  input  2  00 = byte, 01 = half, 10 = word; 11 is treated as word
- ld_unsigned  input  1  zero-extend sub-word loads when 1, sign-extend when 0
- addr  input  32  byte address
- write_data  input  32  store data; byte and half stores use the low bits
- busy  output  1  an access is in flight; new req is ignored
- ready  output  1  one-cycle pulse: access complete
- err  output  1  misaligned flag, valid only while ready=1
- read_data  output  32  load result, held until the next load completes

Behaviour:
- Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4 bytes.
- Storage is 32-bit words, little-endian byte lanes: byte b sits at bits [8b+7:8b].
- Storage is zero-initialised at time zero. Reset does not clear storage.
- FSM states IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE: when req=1, capture we, size, ld_unsigned, addr and write_data, and set busy=1.
  - WAIT>0: go to WAIT with counter = WAIT-1.
  - WAIT=0: go to DONE.
- WAIT: decrement the counter each cycle; go to DONE after the cycle in which the counter is 0.
- DONE: lasts one cycle.
  - Perform the access and pulse ready=1.
  - Clear busy at the same edge that ends DONE. IDLE follows.
- Latency: ready is high exactly WAIT+1 cycles after the accept edge. Minimum throughput is one access per WAIT+2 cycles.
- req while busy is ignored. Input changes after the accept edge have no effect.
- Stores write only the addressed lanes on the DONE edge:
  - byte: lane addr[1:0], from write_data[7:0]
  - half: lanes 2*addr[1] and 2*addr[1]+1, from write_data[15:0]
  - word: all four lanes
- Loads:
  - Word data is read in DONE and the addressed lanes are extracted.
  - Sub-word results are extended per ld_unsigned.
  - read_data is registered and updates on the edge ending DONE, so it is valid the cycle after the ready pulse.
- Misaligned access (half with addr[0]=1, or word with addr[1:0]≠0):
  - Full latency still applies; ready and err pulse together.
  - No storage write occurs; a load sets read_data=0.
- Aligned accesses give err=0.
- Stores leave read_data unchanged.
- Reset values: busy=0, ready=0, err=0, read_data=0, counter=0.
- Reset asserted mid-access aborts it: no write occurs, outputs go to their reset values immediately, and storage is unchanged.

Optional Feature:
- Macro: DMEM_ACCESS_CNT_EN.
- Defined:
  - Adds output ports rd_count[15:0] and wr_count[15:0].
  - Each counter increments on the DONE edge of an aligned load or store respectively.
  - Counters saturate at 16'hFFFF, are cleared by rst_n, and do not count misaligned accesses.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- WAIT=2. Reset, then store word 32'hDEADBEEF at addr 0x10, then load word at 0x10 → ready 3 cycles after each accept, read_data=32'hDEADBEEF, err=0.
- Store byte 8'h80 at 0x13 over 32'h00000000, then load byte signed at 0x13 → 32'hFFFFFF80. Same load with ld_unsigned=1 → 32'h00000080. Load word at 0x10 → 32'h80000000.
- Store half 16'hA55A at 0x22, then load word at 0x20 → 32'hA55A0000. Half store at 0x21 → err=1, word at 0x20 unchanged, busy released.
- Pulse req again 1 cycle after accept with a store to 0x40 → ignored; the word at 0x40 remains 0 and exactly one ready pulse is seen.
- DEPTH=128: store word at 0x200 → lands in word 0; load at 0x000 returns it. WAIT=0 → ready one cycle after accept.
- Assert rst_n low during the WAIT of a store to 0x30 → busy=0 and ready=0 immediately, the word at 0x30 keeps its old value, and the next access completes normally.

Source files
------------

// File: rtl/data_memory_ws.sv
// data_memory_ws: byte-addressed data memory for the MIPS datapath with a
// req/ready handshake, a configurable number of wait states, byte/half/word
// stores, signed or unsigned sub-word loads, misalignment detection and a
// registered read port.
//
// Optional feature macro: DMEM_ACCESS_CNT_EN adds saturating 16-bit
// rd_count / wr_count ports that count aligned loads and stores.
`timescale 1ns/1ps

module data_memory_ws #(
    parameter int DEPTH = 128,  // 32-bit words, power of two, >= 4
    parameter int WAIT  = 2     // extra wait states per access, 0..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        ready,
    output logic        err,
    output logic [31:0] read_data
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   read_data_q, read_data_d;

    // Word storage; starts at zero and is deliberately untouched by rst_n.
    logic [31:0]   mem_q [DEPTH] = '{default: 32'h0};

    logic          misaligned;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [31:0]   load_val;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;
    logic          mem_we;

    // Address bits above the memory size are ignored, so accesses wrap.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^addr[31:AW+2];

    // Next-state logic: accept in IDLE, count wait states, one DONE cycle.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    uns_d   = ld_unsigned;
                    addr_d  = addr[AW+1:0];
                    wdata_d = write_data;
                    if (WAIT > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: alignment check, lane extraction for loads, lane enables for stores.
    always_comb begin
        misaligned = ((size_q == 2'b01) && addr_q[0]) ||
                     (size_q[1] && (addr_q[1:0] != 2'b00));
        word_idx   = addr_q[AW+1:2];
        rd_word    = mem_q[word_idx];
        load_val   = rd_word;
        lane_en    = 4'b1111;
        lane_data  = wdata_q;
        case (size_q)
            2'b00: begin
                load_val  = uns_q ? {24'h0, rd_word[{addr_q[1:0], 3'b000} +: 8]}
                                  : {{24{rd_word[{addr_q[1:0], 3'b111}]}},
                                     rd_word[{addr_q[1:0], 3'b000} +: 8]};
                lane_en   = 4'b0001 << addr_q[1:0];
                lane_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                load_val  = addr_q[1]
                    ? (uns_q ? {16'h0, rd_word[31:16]} : {{16{rd_word[31]}}, rd_word[31:16]})
                    : (uns_q ? {16'h0, rd_word[15:0]}  : {{16{rd_word[15]}}, rd_word[15:0]});
                lane_en   = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata_q[15:0]}};
            end
            default: begin
                load_val  = rd_word;
                lane_en   = 4'b1111;
                lane_data = wdata_q;
            end
        endcase
        mem_we      = (state_q == S_DONE) && we_q && !misaligned;
        read_data_d = read_data_q;
        if ((state_q == S_DONE) && !we_q)
            read_data_d = misaligned ? 32'h0 : load_val;
    end

    // Control and capture registers; an async reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            read_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
        end
    end

    // Storage write on the edge that ends DONE, only the enabled byte lanes.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch on purpose; contents survive
        // rst_n and it can map onto block RAM.
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) mem_q[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign ready     = (state_q == S_DONE);
    assign err       = ready && misaligned;
    assign read_data = read_data_q;

`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    // Saturating counts of aligned loads and stores completed in DONE.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if ((state_q == S_DONE) && !misaligned) begin
            if (we_q && (wr_count_q != 16'hFFFF))  wr_count_d = wr_count_q + 16'd1;
            if (!we_q && (rd_count_q != 16'hFFFF)) rd_count_d = rd_count_q + 16'd1;
        end
    end

    // Counter registers, cleared by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_q <= 16'h0;
            wr_count_q <= 16'h0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    // Access counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_data_memory_ws.sv
// tb_data_memory_ws: directed bench for data_memory_ws. u_dut uses WAIT=2,
// u_dut0 uses WAIT=0; both share every input except req.
`timescale 1ns/1ps

module tb_data_memory_ws;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, req0;
    logic        we;
    logic [1:0]  size;
    logic        ld_unsigned;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        busy, ready, err;
    logic [31:0] read_data;
    logic        busy0, ready0, err0;
    logic [31:0] read_data0;
`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_count, wr_count, rd_count0, wr_count0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_ws #(.DEPTH(128), .WAIT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
        .ld_unsigned(ld_unsigned), .addr(addr), .write_data(write_data),
        .busy(busy), .ready(ready), .err(err), .read_data(read_data)
`ifdef DMEM_ACCESS_CNT_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    data_memory_ws #(.DEPTH(128), .WAIT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .size(size),
        .ld_unsigned(ld_unsigned), .addr(addr), .write_data(write_data),
        .busy(busy0), .ready(ready0), .err(err0), .read_data(read_data0)
`ifdef DMEM_ACCESS_CNT_EN
        , .rd_count(rd_count0), .wr_count(wr_count0)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on u_dut; lat counts negedges from the accept edge to ready.
    // Returns at the negedge after DONE, where read_data is valid.
    task automatic access(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic e);
        @(negedge clk);
        we = w; size = sz; ld_unsigned = u; addr = a; write_data = wd; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        while (!ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = err;
        @(negedge clk);
    endtask

    initial begin
        int   lat;
        logic e;
        int   pulses;

        rst_n = 1'b0; req = 1'b0; req0 = 1'b0; we = 1'b0; size = 2'b10;
        ld_unsigned = 1'b0; addr = 32'h0; write_data = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_read_data", read_data, 32'h0);
        rst_n = 1'b1;

        // Word store then load with WAIT=2 latency.
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, e);
        check("st_word_lat", 32'(lat), 32'd3);
        check("st_word_err", {31'h0, e}, 32'h0);
        check("st_keeps_rd", read_data, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e);
        check("ld_word_lat", 32'(lat), 32'd3);
        check("ld_word_err", {31'h0, e}, 32'h0);
        check("ld_word_data", read_data, 32'hDEADBEEF);
        check("idle_busy", {31'h0, busy}, 32'h0);

        // Byte store into a zeroed word, then sign/zero-extended loads.
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, lat, e);
        access(1'b1, 2'b00, 1'b0, 32'h13, 32'h12345680, lat, e);
        access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, e);
        check("ld_byte_signed", read_data, 32'hFFFFFF80);
        access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, e);
        check("ld_byte_unsigned", read_data, 32'h00000080);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e);
        check("ld_word_after_byte", read_data, 32'h80000000);

        // Half store to upper lanes, half loads, then misaligned accesses.
        access(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFFA55A, lat, e);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, e);
        check("ld_word_after_half", read_data, 32'hA55A0000);
        access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, lat, e);
        check("ld_half_signed", read_data, 32'hFFFFA55A);
        access(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, lat, e);
        check("ld_half_unsigned", read_data, 32'h0000A55A);
        access(1'b1, 2'b01, 1'b0, 32'h21, 32'h00001234, lat, e);
        check("mis_half_lat", 32'(lat), 32'd3);
        check("mis_half_err", {31'h0, e}, 32'h1);
        check("mis_busy_released", {31'h0, busy}, 32'h0);
        check("mis_err_cleared", {31'h0, err}, 32'h0);
        check("mis_keeps_rd", read_data, 32'h0000A55A);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, e);
        check("mis_no_write", read_data, 32'hA55A0000);
        access(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, lat, e);
        check("mis_load_err", {31'h0, e}, 32'h1);
        check("mis_load_zero", read_data, 32'h0);

        // req while busy is ignored; inputs changed after accept have no effect.
        @(negedge clk);
        we = 1'b1; size = 2'b10; addr = 32'h50; write_data = 32'h11111111; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("busy_in_wait", {31'h0, busy}, 32'h1);
        addr = 32'h40; write_data = 32'hCAFEF00D;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req = 1'b0;
            if (ready) pulses++;
        end
        check("one_ready_pulse", 32'(pulses), 32'd1);
        access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, e);
        check("ignored_req_no_write", read_data, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, lat, e);
        check("captured_inputs", read_data, 32'h11111111);

        // Address wrap: 0x200 is word 0 for DEPTH=128.
        access(1'b1, 2'b10, 1'b0, 32'h200, 32'h600DF00D, lat, e);
        access(1'b0, 2'b10, 1'b0, 32'h000, 32'h0, lat, e);
        check("addr_wrap", read_data, 32'h600DF00D);

        // WAIT=0 instance: ready one cycle after accept.
        @(negedge clk);
        we = 1'b1; size = 2'b10; addr = 32'h4; write_data = 32'hA5A5A5A5; req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        check("w0_st_ready", {31'h0, ready0}, 32'h1);
        @(negedge clk);
        check("w0_busy_released", {31'h0, busy0}, 32'h0);
        we = 1'b0; req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        check("w0_ld_ready", {31'h0, ready0}, 32'h1);
        @(negedge clk);
        check("w0_ld_data", read_data0, 32'hA5A5A5A5);

        // Reset during the WAIT phase of a store aborts it.
        access(1'b1, 2'b10, 1'b0, 32'h30, 32'h13579BDF, lat, e);
        @(negedge clk);
        we = 1'b1; size = 2'b10; addr = 32'h30; write_data = 32'hFFFFFFFF; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_ready", {31'h0, ready}, 32'h0);
        check("abort_read_data", read_data, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, e);
        check("abort_lat", 32'(lat), 32'd3);
        check("abort_no_write", read_data, 32'h13579BDF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
